// File: rtl/fx2_fifo_reader.sv
// Pulls 16-bit words from an FX2 slave FIFO into a small circular buffer and hands them to the I2S master on request.
// Optional BYTE_SWAP_EN macro stores each word with its bytes exchanged.
module fx2_fifo_reader #(
  parameter logic [1:0]  EP_ADDR    = 2'b00,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fx2_fd,
  input  logic        fx2_ef_n,
  output logic        fx2_slrd_n,
  output logic        fx2_sloe_n,
  output logic [1:0]  fx2_fifoadr,
  input  logic        data_req,
  output logic [15:0] data_out,
  output logic        half_n,
  output logic        ef_n,
  output logic        underrun
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HALF = CW'(DEPTH / 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nx;
  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  req_q;
  logic                  req_prev;
  logic                  push_c;
  logic                  pop_try_c;
  logic                  pop_c;
  logic [15:0]           fd_word_c;

`ifdef BYTE_SWAP_EN
  assign fd_word_c = {fx2_fd[7:0], fx2_fd[15:8]};
`else
  assign fd_word_c = fx2_fd;
`endif

  assign push_c    = (state == S_STROBE);
  assign pop_try_c = req_q & ~req_prev;
  assign pop_c     = pop_try_c && (count != '0);

  // Fetch sequencing: one FX2 word per SETUP/STROBE/HOLD pass, only when there is room.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (fx2_ef_n && (count < FULL)) state_nx = S_SETUP;
      S_SETUP:  state_nx = S_STROBE;
      S_STROBE: state_nx = S_HOLD;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fx2_slrd_n  <= 1'b1;
      fx2_sloe_n  <= 1'b1;
      fx2_fifoadr <= EP_ADDR;
    end else begin
      state       <= state_nx;
      fx2_slrd_n  <= (state_nx != S_STROBE);
      fx2_sloe_n  <= !((state_nx == S_SETUP) || (state_nx == S_STROBE));
      fx2_fifoadr <= EP_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= fd_word_c;
  end

  // Buffer bookkeeping, request edge detection and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      req_q    <= 1'b0;
      req_prev <= 1'b0;
      data_out <= 16'h0000;
      half_n   <= 1'b1;
      ef_n     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      req_q    <= data_req;
      req_prev <= req_q;
      half_n   <= !(count >= HALF);
      ef_n     <= (count != '0);
      if (push_c) wr_ptr <= wr_ptr + 1'b1;
      if (pop_c) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      if (pop_try_c && (count == '0)) underrun <= 1'b1;
      case ({push_c, pop_c})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fx2_fifo_reader.sv
// Randomised and directed bench for fx2_fifo_reader against a queue-based reference model and an FX2 source model.
module tb_fx2_fifo_reader;

  localparam int DEPTH = 8;
  localparam logic [1:0] EP = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] fx2_fd;
  logic        fx2_ef_n;
  logic        fx2_slrd_n;
  logic        fx2_sloe_n;
  logic [1:0]  fx2_fifoadr;
  logic        data_req = 1'b0;
  logic [15:0] data_out;
  logic        half_n;
  logic        ef_n;
  logic        underrun;

  always #5 clk = ~clk;

  fx2_fifo_reader #(.EP_ADDR(EP), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .fx2_fd(fx2_fd), .fx2_ef_n(fx2_ef_n),
    .fx2_slrd_n(fx2_slrd_n), .fx2_sloe_n(fx2_sloe_n), .fx2_fifoadr(fx2_fifoadr),
    .data_req(data_req), .data_out(data_out), .half_n(half_n), .ef_n(ef_n),
    .underrun(underrun)
  );

  // FX2 source: a word list consumed one entry per low read strobe.
  logic [15:0] src [256];
  int          idx = 0;
  int          src_len = 0;
  int          n_reads = 0;
  logic        ef_force = 1'b0;

  assign fx2_fd   = src[8'(idx)];
  assign fx2_ef_n = ef_force && (idx < src_len);

  always @(posedge clk) begin
    if (!fx2_slrd_n) begin
      idx     <= idx + 1;
      n_reads <= n_reads + 1;
    end
  end

  function automatic logic [15:0] sw(input logic [15:0] w);
`ifdef BYTE_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  // Reference model: words buffered in a queue, pops follow rising edges of the sampled request.
  logic [15:0] mq [$];
  logic        m_req1, m_req2;
  logic [15:0] m_dout;
  logic        m_under, m_efn, m_half, m_start_ok, m_ovf, m_was_reset;
  logic        m_pop;
  int          coincide = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_req1 = 1'b0; m_req2 = 1'b0; m_dout = 16'h0000; m_under = 1'b0;
      m_efn = 1'b0; m_half = 1'b1; m_start_ok = 1'b0; m_ovf = 1'b0; m_was_reset = 1'b1;
    end else begin
      m_was_reset = 1'b0;
      m_efn       = (mq.size() != 0);
      m_half      = !(mq.size() >= DEPTH / 2);
      m_start_ok  = fx2_ef_n && (mq.size() < DEPTH);
      m_pop       = m_req1 && !m_req2;
      if (m_pop && !fx2_slrd_n && mq.size() == DEPTH - 1) coincide++;
      if (m_pop) begin
        if (mq.size() == 0) m_under = 1'b1;
        else m_dout = mq.pop_front();
      end
      if (!fx2_slrd_n) begin
        if (mq.size() >= DEPTH) m_ovf = 1'b1;
        mq.push_back(sw(fx2_fd));
      end
      m_req2 = m_req1;
      m_req1 = data_req;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  int   gap = 100;
  logic p_sloe = 1'b1;
  logic p_slrd = 1'b1;

  task automatic cycle_checks();
    if (m_was_reset) gap = 100;
    gap++;
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("ef_n", 32'(ef_n), 32'(m_efn));
    chk("half_n", 32'(half_n), 32'(m_half));
    chk("fifoadr", 32'(fx2_fifoadr), 32'(EP));
    chk("no_overflow", 32'(m_ovf), 32'd0);
    if (!fx2_slrd_n) begin
      chk("slrd_with_oe", 32'(fx2_sloe_n), 32'd0);
      chk("slrd_after_setup", 32'(p_sloe), 32'd0);
      chk("strobe_gap_ge4", 32'(gap >= 4), 32'd1);
      gap = 0;
    end
    if (!p_slrd) chk("hold_after_strobe", 32'({fx2_slrd_n, fx2_sloe_n}), 32'd3);
    if (!fx2_sloe_n && p_sloe) chk("start_legal", 32'(m_start_ok), 32'd1);
    p_sloe = fx2_sloe_n;
    p_slrd = fx2_slrd_n;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic req_at_release);
    rst_n = 1'b0;
    data_req = 1'b0;
    tick(); tick();
    data_req = req_at_release;
    rst_n = 1'b1;
  endtask

  task automatic load_src(input int n, input bit rnd, input logic [15:0] first);
    for (int i = 0; i < n; i++)
      src[8'(idx + i)] = rnd ? (16'($urandom) | 16'h0100) : 16'(int'(first) + i);
    src_len = idx + n;
  endtask

  task automatic pulse(input int hi, input int lo);
    data_req = 1'b1;
    repeat (hi) tick();
    data_req = 1'b0;
    repeat (lo) tick();
  endtask

  int   base;
  logic found;
  logic seen_a5;

  initial begin
    fork
      forever begin
        @(negedge clk);
        cycle_checks();
      end
    join_none

    // Reset values, then fill from a 16-word FX2 endpoint with no requests.
    do_reset(1'b0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_ef_n", 32'(ef_n), 32'd0);
    chk("rst_half_n", 32'(half_n), 32'd1);
    chk("rst_strobes", 32'({fx2_slrd_n, fx2_sloe_n}), 32'd3);
    load_src(16, 1'b0, 16'h0001);
    ef_force = 1'b1;
    base = n_reads;
    repeat (60) tick();
    chk("fill_reads", 32'(n_reads - base), 32'd8);
    chk("fill_half_n", 32'(half_n), 32'd0);
    chk("fill_ef_n", 32'(ef_n), 32'd1);
    chk("fill_slrd_idle", 32'(fx2_slrd_n), 32'd1);

    // Drain with 20 requests; first one also pins the two-clock latency.
    data_req = 1'b1;
    tick();
    chk("lat_1clk", 32'(data_out), 32'h0);
    tick();
    chk("lat_2clk", 32'(data_out), 32'(sw(16'h0001)));
    data_req = 1'b0;
    repeat (6) tick();
    for (int p = 2; p <= 20; p++) begin
      pulse(2, 6);
      chk("seq_word", 32'(data_out), 32'(sw(16'(p <= 16 ? p : 16))));
      chk("seq_underrun", 32'(underrun), 32'(p >= 17));
    end
    chk("drain_ef_n", 32'(ef_n), 32'd0);

    // Endpoint empty throughout: no reads at all.
    do_reset(1'b0);
    ef_force = 1'b0;
    load_src(100, 1'b1, 16'h0);
    base = n_reads;
    repeat (40) tick();
    chk("empty_reads", 32'(n_reads - base), 32'd0);
    chk("empty_ef_n", 32'(ef_n), 32'd0);
    chk("empty_half_n", 32'(half_n), 32'd1);

    // Pops at swept offsets after a full buffer so a push lands on a pop at count 7.
    ef_force = 1'b1;
    repeat (50) tick();
    for (int d = 1; d <= 8; d++) begin
      pulse(1, d);
      pulse(1, 12);
    end
    chk("coincide_seen", 32'(coincide > 0), 32'd1);

    // Reset while 0x00A5 is being strobed: the word must be discarded.
    do_reset(1'b0);
    ef_force = 1'b0;
    load_src(12, 1'b1, 16'h0);
    src[8'(idx + 2)] = 16'h00A5;
    ef_force = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (!fx2_slrd_n && fx2_fd == 16'h00A5) found = 1'b1;
    end
    chk("a5_strobe_found", 32'(found), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_strobes", 32'({fx2_slrd_n, fx2_sloe_n}), 32'd3);
    chk("mid_rst_data_out", 32'(data_out), 32'h0);
    chk("mid_rst_flags", 32'({half_n, ef_n, underrun}), 32'b100);
    chk("mid_rst_fifoadr", 32'(fx2_fifoadr), 32'(EP));
    rst_n = 1'b1;
    repeat (40) tick();
    seen_a5 = 1'b0;
    for (int p = 0; p < 12; p++) begin
      pulse(2, 6);
      if (data_out == sw(16'h00A5)) seen_a5 = 1'b1;
    end
    chk("a5_not_stored", 32'(seen_a5), 32'd0);

`ifdef BYTE_SWAP_EN
    do_reset(1'b0);
    ef_force = 1'b0;
    load_src(1, 1'b0, 16'h1234);
    ef_force = 1'b1;
    repeat (10) tick();
    pulse(2, 4);
    chk("swap_1234", 32'(data_out), 32'h3412);
`endif

    // Random traffic, request held high across reset release, occasional resets.
    do_reset(1'b1);
    ef_force = 1'b0;
    load_src(200, 1'b1, 16'h0);
    for (int c = 0; c < 3000; c++) begin
      if (src_len - idx < 10) load_src(200, 1'b1, 16'h0);
      data_req = ($urandom_range(0, 3) == 0);
      ef_force = ($urandom_range(0, 7) != 0);
      rst_n    = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    data_req = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fx2_fifo_reader.md
FX2_FIFO_READER -- requirements
Module: fx2_fifo_reader

Interface
REQ-001 SHALL have parameter EP_ADDR, default 2'b00: FX2 endpoint FIFO address driven on fx2_fifoadr.
REQ-002 SHALL have parameter DEPTH_LOG2, default 3: log2 of local buffer depth (8 x 16-bit words).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port fx2_fd  input  16  FX2 slave FIFO data bus.
REQ-006 SHALL have port fx2_ef_n  input  1  FX2 endpoint empty flag, low = empty.
REQ-007 SHALL have port fx2_slrd_n  output  1  FX2 read strobe, active-low.
REQ-008 SHALL have port fx2_sloe_n  output  1  FX2 output enable, active-low.
REQ-009 SHALL have port fx2_fifoadr  output  2  FX2 FIFO address, constant EP_ADDR.
REQ-010 SHALL have port data_req  input  1  word request from i2s_master; rising edge = one pop.
REQ-011 SHALL have port data_out  output  16  current sample word to i2s_master data_in.
REQ-012 SHALL have port half_n  output  1  low when buffer count >= 2^(DEPTH_LOG2-1).
REQ-013 SHALL have port ef_n  output  1  low when buffer count = 0.
REQ-014 SHALL have port underrun  output  1  sticky, set on pop attempt while empty.

Function
REQ-015 SHALL implement a circular buffer of 2^DEPTH_LOG2 words with wrapping read/write pointers and count 0..2^DEPTH_LOG2.
REQ-016 Fetch FSM SHALL have states IDLE, SETUP, STROBE, HOLD.
REQ-017 IDLE->SETUP SHALL occur when fx2_ef_n=1 and count < 2^DEPTH_LOG2; else remain IDLE.
REQ-018 SETUP SHALL drive fx2_sloe_n=0 for one clock, then go to STROBE.
REQ-019 STROBE SHALL drive fx2_sloe_n=0, fx2_slrd_n=0 for exactly one clock and capture fx2_fd into the buffer at that clock's end, then go to HOLD.
REQ-020 HOLD SHALL drive fx2_slrd_n=1, fx2_sloe_n=1 for one clock, then go to IDLE (4 clocks per word minimum).
REQ-021 data_req SHALL be registered and rising-edge detected; a detected edge with count>0 SHALL pop one word.
REQ-022 Popped word SHALL appear on data_out 2 clocks after data_req rises at clk and hold until next pop.
REQ-023 Pop with count=0 SHALL leave data_out unchanged, leave pointers unchanged, and set underrun.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and both SHALL complete.
REQ-025 Push SHALL never occur when count = 2^DEPTH_LOG2 (guaranteed by REQ-017 and single in-flight read).
REQ-026 half_n and ef_n SHALL be registered from count, updating 1 clock after count changes.
REQ-027 fx2_ef_n falling during SETUP or STROBE SHALL NOT abort the read; the transfer completes.

Reset
REQ-028 With rst_n=0 at a clock edge: FSM=IDLE, pointers and count=0, fx2_slrd_n=1, fx2_sloe_n=1, fx2_fifoadr=EP_ADDR, data_out=0, half_n=1, ef_n=0, underrun=0.
REQ-029 Reset asserted mid-transfer SHALL discard the in-flight word; strobes deassert at that edge.
REQ-030 data_req edge detector SHALL reset to 0, so data_req high at reset release counts as an edge.

Configuration
REQ-031 Macro BYTE_SWAP_EN defined: stored word SHALL be {fx2_fd[7:0], fx2_fd[15:8]}.
REQ-032 Macro BYTE_SWAP_EN undefined: stored word SHALL be fx2_fd unchanged.

Verification
REQ-033 FX2 model holds 0x0001..0x0010, fx2_ef_n=1, no data_req -> exactly 8 reads, half_n=0, ef_n=1, fx2_slrd_n idles high.
REQ-034 Then 20 data_req pulses -> data_out sequence 0x0001..0x0010 in order, then ef_n=0, underrun=1 after pulse 17, data_out stays 0x0010.
REQ-035 fx2_ef_n=0 throughout -> fx2_slrd_n never low, ef_n=0, half_n=1.
REQ-036 Buffer at 7 words, push in STROBE coincident with pop edge -> count stays 7, no word lost or duplicated.
REQ-037 rst_n low during STROBE with word 0x00A5 on fx2_fd -> word not stored, all outputs at REQ-028 values next clock.
REQ-038 BYTE_SWAP_EN defined, fx2_fd=0x1234 -> data_out=0x3412 after pop.
